pulse_measure_module: RTL and testbench

- Measures high time and period of a synchronized input signal.
- Sits directly downstream of the edge-grab stage and consumes its single-cycle rising_edge / falling_edge strobes.
- Publishes registered high-time and period counts with a one-cycle valid strobe.
- Flags a timeout when the signal stalls.

---
 rtl/pulse_measure_module.sv | 129 ++++++++++++
 tb/tb_pulse_measure_module.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pulse_measure_module.sv
// Purpose : measures high time and period of a signal from its rising/falling edge strobes.
// Latency : meas_valid / timeout pulse one cycle after the strobe (or stall) that triggers them.
// Backpressure: none; strobes are consumed every cycle, results are held until the next update.

module pulse_measure_module #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rising_edge,
  input  logic             falling_edge,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // Last run-counter value tolerated before a stall is declared.
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RUN_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  // run_q holds the cycle distance from the most recent accepted rising
  // strobe to the current cycle: a rising strobe loads 1 for the following
  // cycle, so sampling run_q in a strobe cycle yields F - R0 or R1 - R0.
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] high_tmp_q, high_tmp_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic             meas_valid_q, meas_valid_d;
  logic             timeout_q, timeout_d;
  logic             stall;

  // A stall is only meaningful while a measurement is in flight; a rising
  // strobe in the same cycle always takes precedence over it.
  assign stall = (state_q != ST_IDLE) && !rising_edge && (run_q == RUN_LAST);

  // Next-state, counter and result logic.
  always_comb begin
    state_d      = state_q;
    run_d        = (state_q == ST_IDLE) ? '0 : (run_q + RUN_ONE);
    high_tmp_d   = high_tmp_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    meas_valid_d = 1'b0;
    timeout_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Falling strobes are meaningless before the first rising edge.
        if (rising_edge) begin
          state_d = ST_HIGH;
          run_d   = RUN_ONE;
        end
      end

      ST_HIGH: begin
        if (rising_edge) begin
          // Rising without a falling in between: restart the period here.
          run_d = RUN_ONE;
        end else if (stall) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
          run_d     = '0;
        end else if (falling_edge) begin
          high_tmp_d = run_q;
          state_d    = ST_LOW;
        end
      end

      ST_LOW: begin
        if (rising_edge) begin
          // Close this period and open the next one in the same cycle so
          // back-to-back periods are measured without a gap.
          high_cnt_d   = high_tmp_q;
          period_cnt_d = run_q;
          meas_valid_d = 1'b1;
          run_d        = RUN_ONE;
          state_d      = ST_HIGH;
        end else if (stall) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
          run_d     = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        run_d   = '0;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      run_q        <= '0;
      high_tmp_q   <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      high_tmp_q   <= high_tmp_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign high_cnt   = high_cnt_q;
  assign period_cnt = period_cnt_q;
  assign meas_valid = meas_valid_q;
  assign timeout    = timeout_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pulse_measure_module.sv
// Directed-vector bench for pulse_measure_module (CNT_W=16, TIMEOUT=64).
// Cycle c starts 1 time unit after the c-th rising clock edge; strobes driven
// in cycle c are sampled at the next edge, so their results appear in cycle c+1.

module tb_pulse_measure_module;

  localparam int CW   = 16;
  localparam int TOUT = 64;
  localparam int MAXC = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rising_edge = 1'b0;
  logic          falling_edge = 1'b0;
  logic [CW-1:0] high_cnt;
  logic [CW-1:0] period_cnt;
  logic          meas_valid;
  logic          timeout;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-test stimulus and expectation tables, indexed by cycle number.
  bit rise_at [MAXC];
  bit fall_at [MAXC];
  bit rst_at  [MAXC];
  bit exp_v   [MAXC];
  bit exp_to  [MAXC];
  int exp_h   [MAXC];
  int exp_p   [MAXC];
  int exp_busy[MAXC];   // -1 = not checked

  pulse_measure_module #(.CNT_W(CW), .TIMEOUT(TOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .rising_edge (rising_edge),
    .falling_edge(falling_edge),
    .high_cnt    (high_cnt),
    .period_cnt  (period_cnt),
    .meas_valid  (meas_valid),
    .timeout     (timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_tables();
    for (int i = 0; i < MAXC; i++) begin
      rise_at[i]  = 1'b0;
      fall_at[i]  = 1'b0;
      rst_at[i]   = 1'b0;
      exp_v[i]    = 1'b0;
      exp_to[i]   = 1'b0;
      exp_h[i]    = 0;
      exp_p[i]    = 0;
      exp_busy[i] = -1;
    end
    rst_at[0] = 1'b1;
    rst_at[1] = 1'b1;
  endtask

  task automatic expect_meas(input int c, input int h, input int p);
    exp_v[c] = 1'b1;
    exp_h[c] = h;
    exp_p[c] = p;
  endtask

  // Plays the tables for ncyc cycles, checking every output each cycle.
  task automatic run_vec(input string name, input int ncyc);
    int hold_h;
    int hold_p;
    hold_h = 0;
    hold_p = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      if (c >= 1 && rst_at[c-1]) begin
        hold_h = 0;
        hold_p = 0;
      end
      if (exp_v[c]) begin
        hold_h = exp_h[c];
        hold_p = exp_p[c];
      end
      if (c >= 2) begin
        check_val($sformatf("%s valid@%0d", name, c), 32'(meas_valid), 32'(exp_v[c]));
        check_val($sformatf("%s timeout@%0d", name, c), 32'(timeout), 32'(exp_to[c]));
        check_val($sformatf("%s high@%0d", name, c), 32'(high_cnt), 32'(hold_h));
        check_val($sformatf("%s period@%0d", name, c), 32'(period_cnt), 32'(hold_p));
        if (exp_busy[c] >= 0)
          check_val($sformatf("%s busy@%0d", name, c), 32'(busy), 32'(exp_busy[c]));
      end
      rst          = rst_at[c];
      rising_edge  = rise_at[c];
      falling_edge = fall_at[c];
    end
    rising_edge  = 1'b0;
    falling_edge = 1'b0;
  endtask

  initial begin
    // Basic: R10 F13 R20 -> valid at 21, high 3, period 10.
    clear_tables();
    rise_at[10] = 1; fall_at[13] = 1; rise_at[20] = 1;
    expect_meas(21, 3, 10);
    exp_busy[2] = 0; exp_busy[10] = 0; exp_busy[11] = 1; exp_busy[21] = 1;
    run_vec("basic", 26);

    // Back-to-back periods with no gap.
    clear_tables();
    rise_at[10] = 1; fall_at[12] = 1; rise_at[15] = 1; fall_at[17] = 1; rise_at[20] = 1;
    expect_meas(16, 2, 5);
    expect_meas(21, 2, 5);
    for (int c = 11; c < 26; c++) exp_busy[c] = 1;
    run_vec("b2b", 26);

    // Timeout: one measurement first, then stall from R10; outputs hold;
    // then the minimum legal period.
    clear_tables();
    rise_at[3] = 1; fall_at[5] = 1; rise_at[10] = 1;
    expect_meas(11, 2, 7);
    exp_to[74] = 1;
    exp_busy[73] = 1; exp_busy[74] = 0; exp_busy[90] = 0;
    rise_at[100] = 1; fall_at[101] = 1; rise_at[102] = 1;
    expect_meas(103, 1, 2);
    exp_busy[103] = 1;
    run_vec("tmo", 108);

    // Rising edge exactly when the run counter reaches TIMEOUT-1 wins.
    clear_tables();
    rise_at[10] = 1; fall_at[12] = 1; rise_at[73] = 1;
    expect_meas(74, 2, 63);
    exp_busy[74] = 1; exp_busy[75] = 1;
    run_vec("tmo_edge", 78);

    // Protocol violation plus falling strobes while idle.
    clear_tables();
    fall_at[4] = 1; fall_at[7] = 1;
    rise_at[10] = 1; rise_at[14] = 1; fall_at[16] = 1; rise_at[24] = 1;
    expect_meas(25, 2, 10);
    exp_busy[8] = 0; exp_busy[10] = 0;
    run_vec("proto", 28);

    // Reset mid-measurement clears outputs and the partial period.
    clear_tables();
    rise_at[3] = 1; fall_at[5] = 1; rise_at[10] = 1;
    expect_meas(11, 2, 7);
    fall_at[12] = 1; rst_at[14] = 1;
    rise_at[20] = 1; fall_at[25] = 1; rise_at[30] = 1;
    expect_meas(31, 5, 10);
    exp_busy[14] = 1; exp_busy[15] = 0; exp_busy[21] = 1;
    run_vec("rstmid", 34);

    // Simultaneous strobes in LOW act as rising; the next period proves HIGH.
    clear_tables();
    rise_at[10] = 1; fall_at[13] = 1;
    rise_at[20] = 1; fall_at[20] = 1;
    expect_meas(21, 3, 10);
    fall_at[24] = 1; rise_at[27] = 1;
    expect_meas(28, 4, 7);
    exp_busy[21] = 1;
    run_vec("simul", 31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
